chan_scan_mux: RTL
==================

# chan_scan_mux

Registered, parametrised N-channel, W-bit multiplexer that generalises the team's 8-to-1 single-bit select mux. It supports a manual select mode and an automatic round-robin scan mode that skips idle channels. It provides a one-cycle registered output with a valid/ready handshake toward the consumer and a per-channel acknowledge pulse back to producers. It sits between a bank of channel sources and a single downstream consumer, such as a serialiser or logger.

## Interface
- `WIDTH`, default 8: data bits per channel.
- `CHANNELS`, default 8: number of input channels, minimum 2.
- `SEL_W`, default $clog2(CHANNELS): select and channel-index width.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low. Asserting it clears all state immediately.
- `mode`, input, 1: 0 = manual (use `sel`), 1 = auto round-robin scan.
- `sel`, input, SEL_W: channel to take in manual mode.
- `data_in`, input, CHANNELS*WIDTH: flat bus; channel k is bits [k*WIDTH +: WIDTH].
- `ch_valid`, input, CHANNELS: bit k high means channel k holds a word to transfer.
- `ch_ack`, output, CHANNELS: one-hot pulse. Bit k is high for exactly the cycle in which channel k's word is captured.
- `out_data`, output, WIDTH: registered selected word.
- `out_ch`, output, SEL_W: index of the channel that `out_data` came from.
- `out_valid`, output, 1: `out_data`/`out_ch` hold a word not yet accepted.
- `out_ready`, input, 1: consumer accepts the word when both `out_valid` and `out_ready` are high.

## Operation
- Define `load = !out_valid || out_ready`. Capture happens only on a cycle where `load` is true.
- **Manual mode:**
  - On `load`, if `sel < CHANNELS` and `ch_valid[sel]` is high:
    - `out_data <= data_in[sel]`, `out_ch <= sel`, `out_valid <= 1`.
    - `ch_ack[sel]` is high this cycle.
  - Otherwise `out_valid <= 0` and `ch_ack` is 0.
  - Manual captures never change `ptr`.
- **Auto mode:**
  - Internal pointer `ptr` (SEL_W bits) marks the highest-priority channel.
  - On `load`, search k = ptr, ptr+1, …, wrapping modulo CHANNELS, for the first k with `ch_valid[k]` high.
  - If found: capture channel k, pulse `ch_ack[k]`, and set `ptr <= (k+1) mod CHANNELS`. Wrap from CHANNELS-1 goes to 0, including when CHANNELS is not a power of 2.
  - If none found: `out_valid <= 0`, no ack, and `ptr` is unchanged.
- **Stall:** while `out_valid && !out_ready`, `out_data`, `out_ch`, `out_valid` and `ptr` hold, and `ch_ack` is 0. Input changes are ignored.
- **Simultaneous accept and new word:** if the output is accepted and a new channel qualifies in the same cycle, the new word is registered the same cycle. This gives back-to-back throughput of one word per cycle.
- **Mode change:** takes effect on the next `load` cycle. `ptr` is neither reset nor advanced by a mode change.
- **`ch_ack` is combinational** from `load`, `mode`, `sel`, `ch_valid` and `ptr`. It is never asserted on a stall cycle.
- **Reset values:** `out_data`=0, `out_ch`=0, `out_valid`=0, `ptr`=0, `ch_ack`=0 (with `rst_n` low).

## Timing
- Latency: a word on `data_in` is visible on `out_data` one clock after the cycle in which its `ch_ack` pulses.
- Throughput: one word per cycle while `out_ready` is held high.
- No combinational path from `data_in` to `out_data`.
- `ch_ack` depends combinationally on `out_ready`, so producers must register it.
- Asserting reset mid-transfer drops any held word immediately: `out_valid` goes to 0 without waiting for a clock edge. After `rst_n` rises, the first capture is possible on the first rising edge.

## Structure
- Shared package `chan_mux_pkg` holds `MODE_MANUAL=1'b0` and `MODE_AUTO=1'b1`, and the `chan_mux_idx_w(n)` helper function.
- One combinational sub-module, `rr_pick`, with parameter CHANNELS:
  - Inputs: request vector and pointer.
  - Outputs: `found`, grant index, and one-hot grant.
  - Implemented as a rotate, priority-encode, un-rotate.
- The top level contains the output register, `ptr`, the mode mux, and `load` logic.

## Test plan
All scenarios use WIDTH=8, CHANNELS=8, with channel k driving data 8'h10+k.

- **Reset:** hold `rst_n` low with all `ch_valid` high. Required: `out_valid`=0 and `ch_ack`=0. After release with `mode`=1 and `out_ready`=1, `out_ch` reads 0, 1, …, 7, 0 on consecutive cycles with data 8'h10…8'h17.
- **Auto skip:** `ch_valid`=8'b1010_0100 and `out_ready`=1. Required: `out_ch` sequence 2, 5, 7, 2, with matching one-hot `ch_ack` pulses.
- **Manual:** `mode`=0, `sel`=3.
  - With `ch_valid[3]`=1: `out_data`=8'h13 and `out_ch`=3 one cycle later.
  - Then drop `ch_valid[3]`: `out_valid`=0 next cycle, and `ptr` is unchanged (confirm by switching to auto).
- **Back-pressure:** in auto mode, hold `out_ready`=0 for 4 cycles after the first capture. Required: output frozen at ch 0 / 8'h10 and `ch_ack`=0 throughout. When `out_ready` returns high, the next captured channel is 1, with no loss or duplicate.
- **Reset mid-stall:** pulse `rst_n` low between clock edges while `out_valid`=1. Required: `out_valid` goes low immediately, and after release scanning restarts at ch 0.
- **Non-power-of-2:** CHANNELS=5, all valid. Required: `out_ch` wraps 4 → 0. With `sel`=6 in manual mode, `out_valid`=0 and no ack.

Source files
------------

// File: rtl/chan_mux_pkg.sv
// rtl/chan_mux_pkg.sv - shared mode encodings and index-width helper for chan_scan_mux
package chan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  function automatic int chan_mux_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: rotate by ptr, priority-encode, un-rotate
module rr_pick
  import chan_mux_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int IDX_W    = chan_mux_idx_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [IDX_W-1:0]    i_ptr,
  output logic                o_found,
  output logic [IDX_W-1:0]    o_idx,
  output logic [CHANNELS-1:0] o_grant
);

  logic [CHANNELS-1:0] w_rot;
  logic [IDX_W-1:0]    w_rot_idx;

  // Modular add for operands already below CHANNELS, so one conditional subtract suffices
  // and non-power-of-2 channel counts wrap correctly.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IDX_W+1)'(CHANNELS)) s = s - (IDX_W+1)'(CHANNELS);
    return s[IDX_W-1:0];
  endfunction

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_rot[i] = i_req[wrap_add(i_ptr, IDX_W'(i))];
    end
  end

  always_comb begin
    o_found   = 1'b0;
    w_rot_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_found   = 1'b1;
        w_rot_idx = IDX_W'(i);
      end
    end
  end

  assign o_idx = wrap_add(i_ptr, w_rot_idx);

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (o_found && (o_idx == IDX_W'(i))) o_grant[i] = 1'b1;
    end
  end

endmodule

// File: rtl/chan_scan_mux.sv
// rtl/chan_scan_mux.sv - registered N-channel mux with manual select or round-robin scan,
// valid/ready output and per-channel acknowledge pulses
module chan_scan_mux
  import chan_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = chan_mux_idx_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       ch_valid,
  output logic [CHANNELS-1:0]       ch_ack,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_ch;
  logic                r_out_valid;
  logic [SEL_W-1:0]    r_ptr;

  logic                w_load;
  logic                w_rr_found;
  logic [SEL_W-1:0]    w_rr_idx;
  logic [CHANNELS-1:0] w_rr_grant;
  logic                w_man_hit;
  logic [CHANNELS-1:0] w_man_oh;
  logic                w_take;
  logic [SEL_W-1:0]    w_idx;
  logic [CHANNELS-1:0] w_oh;
  logic                w_cap;
  logic [WIDTH-1:0]    w_data;
  logic [SEL_W-1:0]    w_ptr_nxt;

  rr_pick #(
    .CHANNELS(CHANNELS),
    .IDX_W   (SEL_W)
  ) u_rr_pick (
    .i_req  (ch_valid),
    .i_ptr  (r_ptr),
    .o_found(w_rr_found),
    .o_idx  (w_rr_idx),
    .o_grant(w_rr_grant)
  );

  // Out-of-range selects match no channel, so they simply produce no capture.
  always_comb begin
    w_man_hit = 1'b0;
    w_man_oh  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) begin
        w_man_hit   = ch_valid[k];
        w_man_oh[k] = ch_valid[k];
      end
    end
  end

  always_comb begin
    w_take = 1'b0;
    w_idx  = '0;
    w_oh   = '0;
    if (mode == MODE_AUTO) begin
      w_take = w_rr_found;
      w_idx  = w_rr_idx;
      w_oh   = w_rr_grant;
    end else begin
      w_take = w_man_hit;
      w_idx  = sel;
      w_oh   = w_man_oh;
    end
  end

  always_comb begin
    w_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_idx == SEL_W'(k)) w_data = data_in[k*WIDTH +: WIDTH];
    end
  end

  assign w_load    = !r_out_valid || out_ready;
  assign w_cap     = w_load && w_take;
  assign ch_ack    = (rst_n && w_cap) ? w_oh : '0;
  assign w_ptr_nxt = (w_rr_idx == SEL_W'(CHANNELS - 1)) ? '0 : w_rr_idx + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else if (w_load) begin
      r_out_valid <= w_take;
      if (w_take) begin
        r_out_data <= w_data;
        r_out_ch   <= w_idx;
      end
      if ((mode == MODE_AUTO) && w_rr_found) r_ptr <= w_ptr_nxt;
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule
